door_guard: RTL and testbench



---
 rtl/door_lock_pkg.sv | 19 +
 rtl/rise_detect.sv | 22 ++
 rtl/door_guard.sv | 120 ++++++++++++
 tb/tb_door_guard.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/door_lock_pkg.sv
// Shared definitions for the door lock datapath: guard state encoding,
// default policy constants and the common counter width.
package door_lock_pkg;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } guard_state_t;

    localparam int CNT_W = 3;

    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_MAX_LOCKOUTS   = 2;
    localparam int DEF_OPEN_CYCLES    = 8;
    localparam int DEF_LOCKOUT_CYCLES = 16;
    localparam int DEF_TMR_W          = 8;

endpackage

// File: rtl/rise_detect.sv
// Single-cycle pulse on the rising edge of a level input.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    // Combinational so the guard reacts on the same edge that samples the input.
    assign pulse = d & ~d_q;

endmodule

// File: rtl/door_guard.sv
// Door relay driver with consecutive-failure lockout and sticky alarm.
// The current guard state is visible as the internal signal 'state'.
module door_guard
    import door_lock_pkg::*;
#(
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int MAX_LOCKOUTS   = DEF_MAX_LOCKOUTS,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int TMR_W          = DEF_TMR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             unlock_in,
    input  logic             error_in,
    input  logic             alarm_clr,
    output logic             door_open,
    output logic             lockout,
    output logic             alarm,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] lock_cnt
);

    localparam logic [TMR_W-1:0] OPEN_LOAD  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAIL_LIMIT = CNT_W'(MAX_FAILS);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCKOUTS);

    guard_state_t     state;
    logic [TMR_W-1:0] timer;
    logic             unlock_rise;
    logic             error_rise;
    logic [CNT_W-1:0] fail_inc;
    logic [CNT_W-1:0] lock_inc;
    logic [CNT_W-1:0] lock_next;
    logic             lock_event;
    logic             alarm_set;

    rise_detect u_unlock_rise (
        .clk   (clk),
        .reset (reset),
        .d     (unlock_in),
        .pulse (unlock_rise)
    );

    rise_detect u_error_rise (
        .clk   (clk),
        .reset (reset),
        .d     (error_in),
        .pulse (error_rise)
    );

    assign fail_inc   = fail_cnt + CNT_W'(1);
    assign lock_inc   = lock_cnt + CNT_W'(1);
    assign lock_next  = (lock_cnt == LOCK_LIMIT) ? lock_cnt : lock_inc;
    assign lock_event = (state == ARMED) && error_rise && (fail_inc == FAIL_LIMIT);
    assign alarm_set  = lock_event && (lock_inc == LOCK_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARMED;
            timer     <= '0;
            door_open <= 1'b0;
            lockout   <= 1'b0;
            alarm     <= 1'b0;
            fail_cnt  <= '0;
            lock_cnt  <= '0;
        end else begin
            case (state)
                ARMED: begin
                    // An error always outranks a coincident unlock.
                    if (error_rise) begin
                        if (lock_event) begin
                            state    <= LOCKOUT;
                            fail_cnt <= '0;
                            lock_cnt <= lock_next;
                            timer    <= LOCK_LOAD;
                            lockout  <= 1'b1;
                        end else begin
                            fail_cnt <= fail_inc;
                        end
                    end else if (unlock_rise && !alarm) begin
                        state     <= OPEN;
                        fail_cnt  <= '0;
                        timer     <= OPEN_LOAD;
                        door_open <= 1'b1;
                    end
                end
                OPEN: begin
                    if (timer != '0) begin
                        timer <= timer - TMR_W'(1);
                    end else begin
                        door_open <= 1'b0;
                        state     <= ARMED;
                    end
                end
                LOCKOUT: begin
                    if (timer != '0) begin
                        timer <= timer - TMR_W'(1);
                    end else begin
                        lockout <= 1'b0;
                        state   <= ARMED;
                    end
                end
                default: begin
                    state <= ARMED;
                end
            endcase

            // A same-cycle alarm set beats the admin clear.
            if (alarm_set) begin
                alarm <= 1'b1;
            end else if (alarm_clr) begin
                alarm    <= 1'b0;
                lock_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_door_guard.sv
// Bench for door_guard: directed scenarios followed by random traffic,
// every cycle compared against an edge-numbered reference model.
module tb_door_guard;

    localparam int MAXF     = 3;
    localparam int MAXL     = 2;
    localparam int OPEN_CYC = 8;
    localparam int LOCK_CYC = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       unlock_in = 1'b0;
    logic       error_in = 1'b0;
    logic       alarm_clr = 1'b0;
    logic       door_open;
    logic       lockout;
    logic       alarm;
    logic [2:0] fail_cnt;
    logic [2:0] lock_cnt;

    int total = 0;
    int bad = 0;

    // Reference model: windows expressed as absolute edge numbers.
    int edge_n = 0;
    int open_until = -1;
    int lock_until = -1;
    int m_fails = 0;
    int m_locks = 0;
    bit m_alarm = 0;
    bit pu = 0;
    bit pe = 0;
    bit exp_door = 0;
    bit exp_lock = 0;
    int open_seen = 0;

    door_guard dut (
        .clk       (clk),
        .reset     (reset),
        .unlock_in (unlock_in),
        .error_in  (error_in),
        .alarm_clr (alarm_clr),
        .door_open (door_open),
        .lockout   (lockout),
        .alarm     (alarm),
        .fail_cnt  (fail_cnt),
        .lock_cnt  (lock_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit u, input bit e, input bit c, input bit r);
        int  m;
        bit  ur;
        bit  er;
        bit  armed;
        bit  aset;
        m = edge_n;
        edge_n++;
        if (r) begin
            open_until = -1;
            lock_until = -1;
            m_fails = 0;
            m_locks = 0;
            m_alarm = 0;
            pu = 0;
            pe = 0;
        end else begin
            ur = u && !pu;
            er = e && !pe;
            pu = u;
            pe = e;
            aset = 0;
            armed = (m > open_until) && (m > lock_until);
            if (armed) begin
                if (er) begin
                    if (m_fails + 1 == MAXF) begin
                        m_fails = 0;
                        lock_until = m + LOCK_CYC;
                        if (m_locks + 1 == MAXL) aset = 1;
                        if (m_locks < MAXL) m_locks++;
                    end else begin
                        m_fails++;
                    end
                end else if (ur && !m_alarm) begin
                    m_fails = 0;
                    open_until = m + OPEN_CYC;
                end
            end
            if (aset) begin
                m_alarm = 1;
            end else if (c) begin
                m_alarm = 0;
                m_locks = 0;
            end
        end
        exp_door = (m < open_until);
        exp_lock = (m < lock_until);
    endtask

    task automatic step(input bit u, input bit e, input bit c, input bit r);
        unlock_in = u;
        error_in  = e;
        alarm_clr = c;
        reset     = r;
        @(posedge clk);
        model_edge(u, e, c, r);
        #1;
        check("door_open", door_open, exp_door);
        check("lockout", lockout, exp_lock);
        check("alarm", alarm, m_alarm);
        check("fail_cnt", fail_cnt, m_fails);
        check("lock_cnt", lock_cnt, m_locks);
        if (door_open === 1'b1) open_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_door", door_open, 0);
        check("rst_fail", fail_cnt, 0);

        // Single unlock pulse: door held for exactly OPEN_CYC cycles
        open_seen = 0;
        step(1, 0, 0, 0);
        check("open_first", door_open, 1);
        idle(10);
        check("open_len", open_seen, OPEN_CYC);
        check("open_fail", fail_cnt, 0);

        // Three errors -> first lockout; unlock inside lockout ignored
        step(0, 1, 0, 0);
        idle(2);
        check("fail_1", fail_cnt, 1);
        step(0, 1, 0, 0);
        idle(2);
        check("fail_2", fail_cnt, 2);
        step(0, 1, 0, 0);
        check("lock_on", lockout, 1);
        check("lock_cnt_1", lock_cnt, 1);
        check("lock_fail0", fail_cnt, 0);
        open_seen = 0;
        idle(5);
        step(1, 0, 0, 0);
        idle(15);
        check("lock_unlock_ign", open_seen, 0);
        check("lock_off", lockout, 0);

        // Second lockout -> alarm; unlock ignored; admin clear; unlock works again
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0);
            idle(2);
        end
        idle(18);
        check("alarm_set", alarm, 1);
        check("lock_cnt_2", lock_cnt, 2);
        open_seen = 0;
        step(1, 0, 0, 0);
        idle(3);
        check("alarm_unlock_ign", open_seen, 0);
        step(0, 0, 1, 0);
        check("alarm_clr", alarm, 0);
        check("clr_lock_cnt", lock_cnt, 0);
        open_seen = 0;
        step(1, 0, 0, 0);
        idle(10);
        check("reopen_len", open_seen, OPEN_CYC);

        // Simultaneous rise: error wins; a held error counts once
        step(1, 1, 0, 0);
        check("simul_fail", fail_cnt, 1);
        check("simul_door", door_open, 0);
        idle(2);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
        idle(2);
        check("held_err", fail_cnt, 2);

        // Unlock clears fails; reset during OPEN
        step(1, 0, 0, 0);
        check("unlock_clr_fail", fail_cnt, 0);
        idle(2);
        step(0, 0, 0, 1);
        check("rst_mid_door", door_open, 0);
        check("rst_mid_fail", fail_cnt, 0);
        check("rst_mid_lock", lock_cnt, 0);
        step(0, 0, 0, 0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
